// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding and default timing parameters for the memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_RETRY = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int DEF_TIMEOUT_CYC = 32;
  localparam int DEF_MAX_RETRY   = 1;

  // True in the states where the cache strobes are driven.
  function automatic logic drives_cache(input state_t st);
    return (st == ST_START) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request bus and cache-side strobe bus of the memory access controller.
interface mem_access_ctrl_if;

  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_busy;
  logic       cpu_done;
  logic [7:0] cpu_rdata;
  logic       cpu_err;
  logic [7:0] addr;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       enable;
  logic       read_en;
  logic       write_en;
  logic       MFC;
  logic       MFCreset;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dataout, MFC,
    input  cpu_busy, cpu_done, cpu_rdata, cpu_err, addr, datain,
           enable, read_en, write_en, MFCreset
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dataout, MFC,
    output cpu_busy, cpu_done, cpu_rdata, cpu_err, addr, datain,
           enable, read_en, write_en, MFCreset
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Loadable saturating up-counter; term flags the last allowed WAIT cycle of an attempt.
module mac_timeout_cnt #(
  parameter int LIMIT = 32,
  parameter int W     = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic clear_n,
  input  logic load,
  input  logic inc,
  output logic term
);

  localparam logic [W-1:0] TERM_V = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX_V  = {W{1'b1}};

  logic [W-1:0] cnt_r;

  // Load has priority; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != MAX_V)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = (cnt_r == TERM_V);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU-to-cache access sequencer with per-attempt timeout and retry.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input logic             clk,
  input logic             clear_n,
  mem_access_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam int AW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [AW-1:0] MAX_RETRY_V = AW'(MAX_RETRY);

  state_t          state_r, state_nx_s;
  logic            we_q_r;
  logic [7:0]      addr_q_r, wdata_q_r, rdata_r;
  logic [AW-1:0]   att_r;
  logic            latch_s, cnt_load_s, cnt_inc_s, att_clr_s, att_inc_s, rd_load_s;
  logic            term_s, we_nx_s, drive_nx_s;
  logic            busy_r, done_r, err_r, en_r, rd_en_r, wr_en_r, mfcreset_r;

  mac_timeout_cnt #(.LIMIT(TIMEOUT_CYC), .W(CW)) u_tmo (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (cnt_load_s),
    .inc     (cnt_inc_s),
    .term    (term_s)
  );

  // Next-state and datapath control; MFC only matters in WAIT.
  always_comb begin
    state_nx_s = state_r;
    latch_s    = 1'b0;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    att_clr_s  = 1'b0;
    att_inc_s  = 1'b0;
    rd_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          latch_s    = 1'b1;
          att_clr_s  = 1'b1;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_load_s = 1'b1;
        state_nx_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.MFC) begin
          rd_load_s  = ~we_q_r;
          state_nx_s = ST_DONE;
        end else if (term_s) begin
          state_nx_s = (att_r < MAX_RETRY_V) ? ST_RETRY : ST_ERR;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_RETRY: begin
        att_inc_s  = 1'b1;
        state_nx_s = ST_START;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      ST_ERR:   state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
    we_nx_s    = latch_s ? bus.cpu_we : we_q_r;
    drive_nx_s = drives_cache(state_nx_s);
  end

  // State, request holding registers, attempt count and read result.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r   <= ST_IDLE;
      we_q_r    <= 1'b0;
      addr_q_r  <= 8'h00;
      wdata_q_r <= 8'h00;
      att_r     <= '0;
      rdata_r   <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      if (latch_s) begin
        we_q_r    <= bus.cpu_we;
        addr_q_r  <= bus.cpu_addr;
        wdata_q_r <= bus.cpu_wdata;
      end
      if (att_clr_s) begin
        att_r <= '0;
      end else if (att_inc_s) begin
        att_r <= att_r + AW'(1);
      end
      if (rd_load_s) begin
        rdata_r <= bus.dataout;
      end
    end
  end

  // Outputs are registered from the next state so they change with the state register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      en_r       <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      mfcreset_r <= 1'b1;
    end else begin
      busy_r     <= (state_nx_s != ST_IDLE);
      done_r     <= (state_nx_s == ST_DONE) || (state_nx_s == ST_ERR);
      err_r      <= (state_nx_s == ST_ERR);
      en_r       <= drive_nx_s;
      rd_en_r    <= drive_nx_s & ~we_nx_s;
      wr_en_r    <= drive_nx_s & we_nx_s;
      mfcreset_r <= ~drive_nx_s;
    end
  end

  assign bus.cpu_busy  = busy_r;
  assign bus.cpu_done  = done_r;
  assign bus.cpu_err   = err_r;
  assign bus.cpu_rdata = rdata_r;
  assign bus.addr      = addr_q_r;
  assign bus.datain    = wdata_q_r;
  assign bus.enable    = en_r;
  assign bus.read_en   = rd_en_r;
  assign bus.write_en  = wr_en_r;
  assign bus.MFCreset  = mfcreset_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized transactions against a cycle-level expectation of the controller's protocol.
module tb_mem_access_ctrl;

  localparam int TMO   = 32;
  localparam int TRIES = 2;
  localparam int PH_IDLE  = 0;
  localparam int PH_DRIVE = 1;
  localparam int PH_DONE  = 2;
  localparam int PH_RETRY = 3;
  localparam int PH_ERR   = 4;

  logic       clk = 1'b0;
  logic       clear_n;
  int         checks = 0;
  int         errors = 0;
  int         mfcr_low;
  logic [7:0] ref_rdata;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected flags {busy,done,err,enable,read_en,write_en,MFCreset} per protocol phase.
  task automatic chk_obs(input string tag, input int ph, input logic we,
                         input logic [7:0] a, input logic [7:0] wd);
    logic [6:0] exp;
    case (ph)
      PH_IDLE:  exp = 7'b000_000_1;
      PH_DRIVE: exp = {3'b100, 1'b1, ~we, we, 1'b0};
      PH_DONE:  exp = 7'b110_000_1;
      PH_RETRY: exp = 7'b100_000_1;
      PH_ERR:   exp = 7'b111_000_1;
      default:  exp = 7'b000_000_0;
    endcase
    if (bus.MFCreset === 1'b0) mfcr_low++;
    chk({tag, ".flags"}, {25'd0, bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.enable,
                          bus.read_en, bus.write_en, bus.MFCreset}, {25'd0, exp});
    chk({tag, ".rdata"}, {24'd0, bus.cpu_rdata}, {24'd0, ref_rdata});
    if (ph == PH_DRIVE) begin
      chk({tag, ".addr"}, {24'd0, bus.addr}, {24'd0, a});
      if (we) chk({tag, ".datain"}, {24'd0, bus.datain}, {24'd0, wd});
    end
  endtask

  // d0/d1: WAIT cycle (1..TMO) of attempt 0/1 in which MFC is presented; anything else never.
  task automatic run_txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] dout, input int d0, input int d1, input bit poke);
    int  d;
    bit  fin;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.dataout = dout; mfcr_low = 0; fin = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = ~we; bus.cpu_addr = ~a; bus.cpu_wdata = ~wd;
    for (int att = 0; att < TRIES && !fin; att++) begin
      d = (att == 0) ? d0 : d1;
      chk_obs("start", PH_DRIVE, we, a, wd);
      bus.MFC = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int w = 1; w <= TMO && !fin; w++) begin
        chk_obs("wait", PH_DRIVE, we, a, wd);
        bus.MFC = (w == d);
        if (poke && w == 2) begin
          bus.cpu_req = 1'b1; bus.cpu_addr = 8'h44;
        end else begin
          bus.cpu_req = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        bus.MFC = 1'b0; bus.cpu_req = 1'b0;
        if (w == d) begin
          if (!we) ref_rdata = dout;
          chk_obs("done", PH_DONE, we, a, wd);
          fin = 1'b1;
        end else if (w == TMO) begin
          if (att < TRIES - 1) begin
            chk_obs("retry", PH_RETRY, we, a, wd);
            bus.MFC = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.MFC = 1'b0;
          end else begin
            chk_obs("err", PH_ERR, we, a, wd);
            fin = 1'b1;
          end
        end
      end
    end
    @(posedge clk); @(negedge clk);
    chk_obs("idle", PH_IDLE, we, a, wd);
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    bus.dataout = 8'h00; bus.MFC = 1'b0; clear_n = 1'b0; ref_rdata = 8'h00; mfcr_low = 0;
    repeat (2) @(negedge clk);
    chk_obs("reset", PH_IDLE, 1'b0, 8'h00, 8'h00);
    chk("reset.addr", {24'd0, bus.addr}, 32'd0);
    chk("reset.datain", {24'd0, bus.datain}, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 8'h13, 8'h00, 8'h2A, 7, 0, 1'b0);
    chk("read.mfcreset_low", mfcr_low, 32'd8);
    run_txn(1'b1, 8'hF0, 8'h5C, 8'hEE, 3, 0, 1'b0);
    chk("write.mfcreset_low", mfcr_low, 32'd4);
    run_txn(1'b0, 8'h21, 8'h00, 8'h77, 0, 0, 1'b0);
    chk("timeout.mfcreset_low", mfcr_low, TRIES * (TMO + 1));
    run_txn(1'b0, 8'h22, 8'h00, 8'h99, 0, TMO, 1'b0);
    run_txn(1'b0, 8'h30, 8'h00, 8'h55, 5, 0, 1'b1);

    // Abort a read mid-WAIT with an asynchronous clear.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h66; bus.dataout = 8'hAB;
    @(posedge clk); @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    clear_n = 1'b0; ref_rdata = 8'h00;
    #1;
    chk_obs("clear", PH_IDLE, 1'b0, 8'h00, 8'h00);
    chk("clear.addr", {24'd0, bus.addr}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("clear.done", {31'd0, bus.cpu_done}, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 8'h13, 8'h00, 8'h3C, 2, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
